// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential mantissa divider: FSM state type,
// default operand sizes and the iteration-counter width helper.
package fp_div_pkg;

   localparam int DEF_WIDTH = 24;
   localparam int DEF_QBITS = 26;

   // Width needed to hold an iteration index 0 .. q-1
   function automatic int cntWidth(input int q);
      return (q > 1) ? $clog2(q) : 1;
   endfunction

   localparam int CNT_W = cntWidth(DEF_QBITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fp_mant_div_seq_if.sv
// Request/result bundle for the mantissa divider. The master issues a start
// with both mantissas; the slave (divider) returns quotient, sticky and
// divide-by-zero flags with a one-cycle valid pulse.
interface fp_mant_div_seq_if
   import fp_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int QBITS = DEF_QBITS
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             valid;
   logic [QBITS-1:0] quotient;
   logic             sticky;
   logic             div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, valid, quotient, sticky, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, valid, quotient, sticky, div_zero
   );

endinterface

// File: rtl/fp_div_row.sv
// One restoring-division row: a ripple chain of subtract/select cells that
// computes rem - div as rem + ~div + 1. The carry out of the top cell means
// rem >= div and selects the difference in every cell; otherwise the row
// passes the remainder through unchanged.
module fp_div_row #(
   parameter int N = 25
) (
   input  logic [N-1:0] rem_i,
   input  logic [N-1:0] div_i,
   output logic [N-1:0] next_o,
   output logic         carry_o
);

   logic [N:0]   carry;
   logic [N-1:0] diff;

   assign carry[0] = 1'b1;

   // Subtract/select cell per bit: full adder on (rem, ~div, carry-in),
   // result muxed by the row-wide select taken from the final carry
   for (genvar i = 0; i < N; i++) begin : gCell
      logic notB;
      assign notB       = ~div_i[i];
      assign diff[i]    = rem_i[i] ^ notB ^ carry[i];
      assign carry[i+1] = (rem_i[i] & notB) | (rem_i[i] & carry[i]) | (notB & carry[i]);
      assign next_o[i]  = carry[N] ? diff[i] : rem_i[i];
   end

   assign carry_o = carry[N];

endmodule

// File: rtl/fp_mant_div_seq.sv
// Sequential radix-2 restoring divider for normalized mantissas. One quotient
// bit is resolved per clock, MSB (integer bit) first, and a sticky flag
// reports a nonzero final remainder for the downstream rounder.
// Optional build macro FP_DIV_EARLY_TERM_EN: finish as soon as the partial
// remainder becomes zero (remaining quotient bits are already zero).
module fp_mant_div_seq
   import fp_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int QBITS = DEF_QBITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_mant_div_seq_if.slave     bus
);

   localparam int CW = cntWidth(QBITS);

   state_e           state_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   div_q;
   logic [CW-1:0]    count_q;
   logic [QBITS-1:0] quot_q;
   logic             sticky_q;
   logic             divZero_q;
   logic             valid_q;
   logic             busy_q;

   logic [WIDTH:0]   rowNext;
   logic             rowCarry;
   logic [WIDTH:0]   rem_d;

   fp_div_row #(.N(WIDTH + 1)) uRow (
      .rem_i   (rem_q),
      .div_i   (div_q),
      .next_o  (rowNext),
      .carry_o (rowCarry)
   );

   // Next partial remainder: selected row output shifted left one place.
   // The invariant rem < 2*div keeps the shifted value within WIDTH+1 bits.
   assign rem_d = rowNext << 1;

   // Control FSM with registered outputs: load, iterate, then a one-cycle
   // result pulse; divide-by-zero skips the iteration entirely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         div_q     <= '0;
         count_q   <= '0;
         quot_q    <= '0;
         sticky_q  <= 1'b0;
         divZero_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.divisor != '0) begin
                     rem_q     <= {1'b0, bus.dividend};
                     div_q     <= {1'b0, bus.divisor};
                     quot_q    <= '0;
                     divZero_q <= 1'b0;
                     count_q   <= CW'(QBITS - 1);
                     state_q   <= CALC;
                  end else begin
                     quot_q    <= '1;
                     sticky_q  <= 1'b0;
                     divZero_q <= 1'b1;
                     valid_q   <= 1'b1;
                     state_q   <= DONE;
                  end
               end
            end
            CALC: begin
               quot_q[count_q] <= rowCarry;
               rem_q           <= rem_d;
               if (count_q == '0) begin
                  sticky_q <= (rem_d != '0);
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else begin
`ifdef FP_DIV_EARLY_TERM_EN
                  if (rem_d == '0) begin
                     sticky_q <= 1'b0;
                     valid_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     count_q <= count_q - 1'b1;
                  end
`else
                  count_q <= count_q - 1'b1;
`endif
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.valid    = valid_q;
   assign bus.quotient = quot_q;
   assign bus.sticky   = sticky_q;
   assign bus.div_zero = divZero_q;

endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Self-checking bench for fp_mant_div_seq: a table of directed vectors, a
// batch of random normalized operands scored against an arithmetic model,
// and hand-written sequences for ignored starts, async reset and
// back-to-back operation.
module tb_fp_mant_div_seq;

   localparam int WIDTH = 24;
   localparam int QBITS = 26;
   localparam int LAT_LIMIT = 40;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [QBITS-1:0] q;
      logic             s;
      logic             dz;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   passCount;
   vec_t vecs[6];

   fp_mant_div_seq_if #(.WIDTH(WIDTH), .QBITS(QBITS)) ifc ();

   fp_mant_div_seq #(.WIDTH(WIDTH), .QBITS(QBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: quotient = floor(a * 2^(QBITS-1) / b)
   function automatic logic [QBITS-1:0] modelQuot(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint n;
      if (b == 0) return '1;
      n = longint'(a) << (QBITS - 1);
      return QBITS'(n / longint'(b));
   endfunction

   function automatic logic modelSticky(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint n;
      if (b == 0) return 1'b0;
      n = longint'(a) << (QBITS - 1);
      return (n % longint'(b)) != 0;
   endfunction

   // Edges from the start-sampling edge to the edge that raises valid
   function automatic int modelLatency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (b == 0) return 0;
`ifdef FP_DIV_EARLY_TERM_EN
      for (int k = 1; k <= QBITS; k++) begin
         if (((longint'(a) << (k - 1)) % longint'(b)) == 0) return k;
      end
`endif
      return QBITS;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Pulse start for one cycle; returns just after the sampling edge
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      ifc.start    = 1'b1;
      ifc.dividend = a;
      ifc.divisor  = b;
      @(posedge clk); #1;
      ifc.start = 1'b0;
   endtask

   // Count edges until valid, optionally pulsing a spurious start at edge injectAt
   task automatic waitValid(input int injectAt, output int lat, output logic busyGap);
      lat     = 0;
      busyGap = 1'b0;
      while (!ifc.valid && lat < LAT_LIMIT) begin
         if (lat == injectAt) begin
            ifc.start    = 1'b1;
            ifc.dividend = 24'hC00000;
            ifc.divisor  = 24'h800000;
         end
         @(posedge clk); #1;
         ifc.start = 1'b0;
         lat++;
         if (!ifc.busy && !ifc.valid) busyGap = 1'b1;
      end
      if (!ifc.valid) lat = -1;
   endtask

   // Full operation: start, wait, score, then confirm the pulse ends in IDLE
   task automatic runOp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [QBITS-1:0] q, input logic s, input logic dz, input int injectAt);
      int   lat;
      logic gap;
      applyStimulus(a, b);
      checkOutput({name, " busy at start"}, longint'(ifc.busy), 1);
      waitValid(injectAt, lat, gap);
      checkOutput({name, " latency"}, longint'(lat), longint'(modelLatency(a, b)));
      checkOutput({name, " busy gap"}, longint'(gap), 0);
      checkOutput({name, " quotient"}, longint'(ifc.quotient), longint'(q));
      checkOutput({name, " sticky"}, longint'(ifc.sticky), longint'(s));
      checkOutput({name, " div_zero"}, longint'(ifc.div_zero), longint'(dz));
      @(posedge clk); #1;
      checkOutput({name, " valid one-shot"}, longint'(ifc.valid), 0);
      checkOutput({name, " busy after"}, longint'(ifc.busy), 0);
      checkOutput({name, " quotient hold"}, longint'(ifc.quotient), longint'(q));
   endtask

   // Main test sequence
   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      checkCount   = 0;
      passCount    = 0;
      rst_n        = 1'b0;
      ifc.start    = 1'b0;
      ifc.dividend = '0;
      ifc.divisor  = '0;

      vecs[0] = '{a: 24'hC00000, b: 24'h800000, q: 26'h3000000, s: 1'b0, dz: 1'b0};
      vecs[1] = '{a: 24'h800000, b: 24'hC00000, q: 26'h1555555, s: 1'b1, dz: 1'b0};
      vecs[2] = '{a: 24'h9ABCDE, b: 24'h000000, q: 26'h3FFFFFF, s: 1'b0, dz: 1'b1};
      vecs[3] = '{a: 24'h800000, b: 24'h800000, q: 26'h2000000, s: 1'b0, dz: 1'b0};
      vecs[4] = '{a: 24'hFFFFFF, b: 24'h800000, q: 26'h3FFFFFC, s: 1'b0, dz: 1'b0};
      vecs[5] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, q: 26'h2000000, s: 1'b0, dz: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", longint'(ifc.busy), 0);
      checkOutput("reset valid", longint'(ifc.valid), 0);
      checkOutput("reset quotient", longint'(ifc.quotient), 0);
      checkOutput("reset sticky", longint'(ifc.sticky), 0);
      checkOutput("reset div_zero", longint'(ifc.div_zero), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].s, vecs[i].dz, -1);
      end

      // Spurious start during CALC is ignored, next start in IDLE accepted
      runOp("ignored start", 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 5);
      runOp("after ignore", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, -1);

      // Asynchronous reset mid-CALC (count = 10 after 15 CALC edges)
      applyStimulus(24'h800000, 24'hC00000);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", longint'(ifc.busy), 0);
      checkOutput("abort valid", longint'(ifc.valid), 0);
      checkOutput("abort quotient", longint'(ifc.quotient), 0);
      checkOutput("abort sticky", longint'(ifc.sticky), 0);
      checkOutput("abort div_zero", longint'(ifc.div_zero), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         checkOutput("no valid after abort", longint'(ifc.valid), 0);
      end
      runOp("post reset", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, -1);

      // Random normalized operands, issued back-to-back against the model
      for (int i = 0; i < 20; i++) begin
         ra = 24'($urandom) | 24'h800000;
         rb = 24'($urandom) | 24'h800000;
         runOp($sformatf("rand%0d", i), ra, rb, modelQuot(ra, rb), modelSticky(ra, rb), 1'b0, -1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
